// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encodings match the datapath's ForwardAE/BE mux ordering.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_flags_t;

    // The M-stage result is newer than W, so it takes priority on a double match.
    function automatic logic [1:0] fwd_sel(input logic match_m, input logic wr_m,
                                           input logic match_w, input logic wr_w);
        if (match_m && wr_m) begin
            return FWD_MEM;
        end else if (match_w && wr_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Control bundle between the hazard unit and the datapath/decoder.
// The master side is the hazard unit; the slave side is the datapath.
interface hazard_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             RegWriteD;
    logic             MemtoRegD;
    logic             PCSrcD;
    logic             CondExE;
    logic             BranchTakenE;
    logic             Match_1E_M;
    logic             Match_1E_W;
    logic             Match_2E_M;
    logic             Match_2E_W;
    logic             Match_12D_E;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             RegWriteW;
    logic             MemtoRegW;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output RegWriteW, MemtoRegW, StallCount, FlushCount
    );

    modport slave (
        output RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  RegWriteW, MemtoRegW, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_unit_ctrl_flag_reg.sv
// N-bit pipeline flag register with synchronous active-low reset and
// synchronous clear (used to bubble a stage).
module ctrl_flag_reg #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] flag_d;
    logic [N-1:0] flag_q;

    always_comb begin
        flag_d = d;
        if (clr) begin
            flag_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q = flag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage ARM pipeline: carries per-instruction
// qualifiers through E/M/W and derives forwarding, stall and flush controls.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.master hz
);

    ctrl_flags_t      flags_d;
    ctrl_flags_t      flags_e;
    ctrl_flags_t      flags_m_in;
    ctrl_flags_t      flags_m;
    ctrl_flags_t      flags_w;
    logic             ld_stall;
    logic             pc_wr_pending;
    logic             stall_f;
    logic             flush_d;
    logic             flush_e;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;

    always_comb begin
        flags_d    = '{reg_write: hz.RegWriteD, mem_to_reg: hz.MemtoRegD, pc_src: hz.PCSrcD};
        flags_m_in = '{reg_write:  flags_e.reg_write & hz.CondExE,
                       mem_to_reg: flags_e.mem_to_reg,
                       pc_src:     flags_e.pc_src & hz.CondExE};
    end

    ctrl_flag_reg #(.N($bits(ctrl_flags_t))) u_flags_e (
        .clk(clk), .reset(reset), .clr(flush_e), .d(flags_d), .q(flags_e)
    );

    ctrl_flag_reg #(.N($bits(ctrl_flags_t))) u_flags_m (
        .clk(clk), .reset(reset), .clr(1'b0), .d(flags_m_in), .q(flags_m)
    );

    ctrl_flag_reg #(.N($bits(ctrl_flags_t))) u_flags_w (
        .clk(clk), .reset(reset), .clr(1'b0), .d(flags_m), .q(flags_w)
    );

    always_comb begin
        ld_stall      = hz.Match_12D_E & flags_e.mem_to_reg;
        pc_wr_pending = hz.PCSrcD | flags_e.pc_src | flags_m.pc_src;
        stall_f       = ld_stall | pc_wr_pending;
        flush_d       = pc_wr_pending | flags_w.pc_src | hz.BranchTakenE;
        flush_e       = ld_stall | hz.BranchTakenE;
    end

    // Controls are forced low while reset is held, independent of live D/E inputs.
    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.RegWriteW = 1'b0;
        hz.MemtoRegW = 1'b0;
        if (reset) begin
            hz.ForwardAE = fwd_sel(hz.Match_1E_M, flags_m.reg_write, hz.Match_1E_W, flags_w.reg_write);
            hz.ForwardBE = fwd_sel(hz.Match_2E_M, flags_m.reg_write, hz.Match_2E_W, flags_w.reg_write);
            hz.StallF    = stall_f;
            hz.StallD    = ld_stall;
            hz.FlushD    = flush_d;
            hz.FlushE    = flush_e;
            hz.RegWriteW = flags_w.reg_write;
            hz.MemtoRegW = flags_w.mem_to_reg;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((flush_d || flush_e) && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: each task queues expected control values
// per cycle and compares them against the DUT on the falling edge.
module tb_hazard_unit;

    localparam int unsigned CW = 4;

    typedef enum int {S_FAE, S_FBE, S_STF, S_STD, S_FLD, S_FLE, S_RWW, S_MRW, S_SC, S_FC} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    exp_t e;
    logic [31:0] o;
    int n_pass;
    int n_tot;
    int exp_sc;
    int exp_fc;

    hazard_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input sig_e s);
        case (s)
            S_FAE:   return {30'd0, hz.ForwardAE};
            S_FBE:   return {30'd0, hz.ForwardBE};
            S_STF:   return {31'd0, hz.StallF};
            S_STD:   return {31'd0, hz.StallD};
            S_FLD:   return {31'd0, hz.FlushD};
            S_FLE:   return {31'd0, hz.FlushE};
            S_RWW:   return {31'd0, hz.RegWriteW};
            S_MRW:   return {31'd0, hz.MemtoRegW};
            S_SC:    return {28'd0, hz.StallCount};
            S_FC:    return {28'd0, hz.FlushCount};
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string name, input sig_e s, input logic [31:0] v);
        exp_t x;
        x.name = name;
        x.sig  = s;
        x.val  = v;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.RegWriteD    = 1'b0;
        hz.MemtoRegD    = 1'b0;
        hz.PCSrcD       = 1'b0;
        hz.CondExE      = 1'b0;
        hz.BranchTakenE = 1'b0;
        hz.Match_1E_M   = 1'b0;
        hz.Match_1E_W   = 1'b0;
        hz.Match_2E_M   = 1'b0;
        hz.Match_2E_W   = 1'b0;
        hz.Match_12D_E  = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        push("rst_fae", S_FAE, 0); push("rst_fbe", S_FBE, 0);
        push("rst_stf", S_STF, 0); push("rst_std", S_STD, 0);
        push("rst_fld", S_FLD, 0); push("rst_fle", S_FLE, 0);
        push("rst_rww", S_RWW, 0); push("rst_mrw", S_MRW, 0);
        push("rst_sc", S_SC, 0);   push("rst_fc", S_FC, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs(e.sig); n_tot++;
            if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
            else n_pass++;
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_alu_forward();
        idle(4);
        hz.RegWriteD = 1'b1;
        tick();
        hz.RegWriteD = 1'b0;
        hz.CondExE   = 1'b1;
        tick();
        for (int c = 2; c < 5; c++) begin
            clear_inputs();
            hz.CondExE = 1'b1;
            if (c == 2) begin
                hz.Match_1E_M = 1'b1;
                push("alu_fae_m", S_FAE, 2); push("alu_fbe_m", S_FBE, 0);
            end else if (c == 3) begin
                hz.Match_2E_W = 1'b1;
                push("alu_fbe_w", S_FBE, 1); push("alu_fae_w", S_FAE, 0);
                push("alu_rww", S_RWW, 1);
            end else begin
                hz.Match_2E_W = 1'b1;
                push("alu_fbe_done", S_FBE, 0); push("alu_rww_done", S_RWW, 0);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = obs(e.sig); n_tot++;
                if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_double_match();
        idle(4);
        hz.RegWriteD = 1'b1;
        tick();
        hz.CondExE = 1'b1;
        tick();
        hz.RegWriteD = 1'b0;
        tick();
        hz.Match_1E_M = 1'b1;
        hz.Match_1E_W = 1'b1;
        hz.Match_2E_W = 1'b1;
        push("dbl_fae", S_FAE, 2);
        push("dbl_fbe", S_FBE, 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs(e.sig); n_tot++;
            if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_load_use();
        idle(4);
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c == 0) begin
                hz.MemtoRegD = 1'b1;
                hz.RegWriteD = 1'b1;
                push("ld_c0_stf", S_STF, 0);
            end else begin
                hz.Match_12D_E = 1'b1;
                push($sformatf("ld_c%0d_stf", c), S_STF, (c == 1) ? 1 : 0);
                push($sformatf("ld_c%0d_std", c), S_STD, (c == 1) ? 1 : 0);
                push($sformatf("ld_c%0d_fle", c), S_FLE, (c == 1) ? 1 : 0);
                push($sformatf("ld_c%0d_fld", c), S_FLD, 0);
                push($sformatf("ld_c%0d_sc", c), S_SC, (c == 1) ? exp_sc : exp_sc + 1);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = obs(e.sig); n_tot++;
                if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
                else n_pass++;
            end
            tick();
        end
        exp_sc += 1;
        exp_fc += 1;
    endtask

    task automatic test_pc_write(input logic cond);
        logic [4:0] stf;
        logic [4:0] fld;
        stf = cond ? 5'b00111 : 5'b00011;
        fld = cond ? 5'b01111 : 5'b00011;
        idle(4);
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            hz.PCSrcD  = (c == 0);
            hz.CondExE = (c == 1) ? cond : 1'b0;
            push($sformatf("pc%0d_c%0d_stf", cond, c), S_STF, {31'd0, stf[c]});
            push($sformatf("pc%0d_c%0d_fld", cond, c), S_FLD, {31'd0, fld[c]});
            push($sformatf("pc%0d_c%0d_std", cond, c), S_STD, 0);
            push($sformatf("pc%0d_c%0d_fle", cond, c), S_FLE, 0);
            if (c == 4) begin
                push($sformatf("pc%0d_sc", cond), S_SC, exp_sc + (cond ? 3 : 2));
                push($sformatf("pc%0d_fc", cond), S_FC, exp_fc + (cond ? 4 : 2));
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = obs(e.sig); n_tot++;
                if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
                else n_pass++;
            end
            tick();
        end
        exp_sc += cond ? 3 : 2;
        exp_fc += cond ? 4 : 2;
    endtask

    task automatic test_cond_fail();
        idle(4);
        hz.RegWriteD = 1'b1;
        tick();
        hz.RegWriteD = 1'b0;
        hz.CondExE   = 1'b0;
        tick();
        hz.CondExE    = 1'b1;
        hz.Match_1E_M = 1'b1;
        push("cf_fae", S_FAE, 0);
        @(negedge clk);
        tick();
        push("cf_rww", S_RWW, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs(e.sig); n_tot++;
            if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_branch();
        idle(4);
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    hz.BranchTakenE = 1'b1;
                    push("br_fld", S_FLD, 1); push("br_fle", S_FLE, 1);
                    push("br_stf", S_STF, 0); push("br_std", S_STD, 0);
                end
                1: hz.MemtoRegD = 1'b1;
                2: begin
                    hz.BranchTakenE = 1'b1;
                    hz.Match_12D_E  = 1'b1;
                    push("brld_fld", S_FLD, 1); push("brld_fle", S_FLE, 1);
                    push("brld_stf", S_STF, 1); push("brld_std", S_STD, 1);
                end
                default: begin
                    push("brld_after_stf", S_STF, 0); push("brld_after_fle", S_FLE, 0);
                    push("br_sc", S_SC, exp_sc + 1);  push("br_fc", S_FC, exp_fc + 2);
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = obs(e.sig); n_tot++;
                if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
                else n_pass++;
            end
            tick();
        end
        exp_sc += 1;
        exp_fc += 2;
    endtask

    task automatic test_saturation_reset();
        idle(4);
        hz.PCSrcD = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        clear_inputs();
        push("sat_sc", S_SC, (1 << CW) - 1);
        push("sat_fc", S_FC, (1 << CW) - 1);
        @(negedge clk);
        idle(5);
        push("sat_hold_sc", S_SC, (1 << CW) - 1);
        push("sat_hold_fc", S_FC, (1 << CW) - 1);
        @(negedge clk);
        tick();
        hz.PCSrcD = 1'b1;
        tick();
        hz.PCSrcD = 1'b0;
        reset = 1'b0;
        push("rmid_stf", S_STF, 0); push("rmid_fld", S_FLD, 0);
        push("rmid_fle", S_FLE, 0); push("rmid_std", S_STD, 0);
        push("rmid_sc", S_SC, (1 << CW) - 1);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs(e.sig); n_tot++;
            if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
            else n_pass++;
        end
        tick();
        reset = 1'b1;
        push("rrel_stf", S_STF, 0); push("rrel_fld", S_FLD, 0);
        push("rrel_fle", S_FLE, 0); push("rrel_std", S_STD, 0);
        push("rrel_sc", S_SC, 0);   push("rrel_fc", S_FC, 0);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs(e.sig); n_tot++;
            if (o !== e.val) $display("FAIL %s got=%0h exp=%0h", e.name, o, e.val);
            else n_pass++;
        end
        tick();
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        exp_sc = 0;
        exp_fc = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_alu_forward();
        test_double_match();
        test_load_use();
        test_pc_write(1'b1);
        test_pc_write(1'b0);
        test_cond_fail();
        test_branch();
        test_saturation_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
